// File: rtl/tone_seq_ctrl.sv
// Tone sequencer driving a downstream PWM generator: a single key-click tone or a three-beep error alarm.
// Optional error preemption of key clicks is enabled by defining TONE_SEQ_PREEMPT_EN.
module tone_seq_ctrl #(
  parameter int          TICK_DIV   = 50000,
  parameter logic [31:0] KEY_PERIOD = 32'd113635,
  parameter int          KEY_TICKS  = 30,
  parameter logic [31:0] ERR_PERIOD = 32'd227271,
  parameter int          ERR_TICKS  = 100,
  parameter int          GAP_TICKS  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_req,
  input  logic        err_req,
  output logic        key_ack,
  output logic        err_ack,
  output logic [31:0] period,
  output logic [31:0] duty,
  output logic        pwm_rst_n,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   KEY_LAST   = 16'(KEY_TICKS - 1);
  localparam logic [15:0]   ERR_LAST   = 16'(ERR_TICKS - 1);
  localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICKS - 1);
  localparam logic [31:0]   KEY_DUTY   = (KEY_PERIOD >> 1) + 32'd1;
  localparam logic [31:0]   ERR_DUTY   = (ERR_PERIOD >> 1) + 32'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tick_q, tick_d;
  logic [1:0]    beep_q, beep_d;
  logic          err_seq_q, err_seq_d;
  logic          key_pend_q, key_pend_d;
  logic          err_pend_q, err_pend_d;
  logic [31:0]   period_q, period_d;
  logic [31:0]   duty_q, duty_d;
  logic          key_ack_q, key_ack_d;
  logic          err_ack_q, err_ack_d;
  logic          pwm_rst_n_q, pwm_rst_n_d;
  logic          busy_q, busy_d;

  logic        presc_wrap;
  logic [15:0] tick_last;
  logic        seg_done;
  logic        start_err;
  logic        start_key;

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign seg_done   = presc_wrap && (tick_q == tick_last);

  always_comb begin
    tick_last = KEY_LAST;
    if (state_q == ST_GAP) begin
      tick_last = GAP_LAST;
    end else if (err_seq_q) begin
      tick_last = ERR_LAST;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    beep_d     = beep_q;
    err_seq_d  = err_seq_q;
    key_pend_d = key_pend_q;
    err_pend_d = err_pend_q;
    period_d   = period_q;
    duty_d     = duty_q;
    key_ack_d  = 1'b0;
    err_ack_d  = 1'b0;
    start_err  = 1'b0;
    start_key  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (err_req || err_pend_q) begin
          start_err = 1'b1;
          if (key_req) begin
            key_pend_d = 1'b1;
          end
        end else if (key_req || key_pend_q) begin
          start_key = 1'b1;
        end
      end
      ST_TONE, ST_GAP: begin
        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        if (presc_wrap) begin
          tick_d = tick_q + 16'd1;
        end
        if (seg_done) begin
          presc_d = '0;
          tick_d  = '0;
          if (state_q == ST_TONE) begin
            state_d = (err_seq_q && beep_q != 2'd2) ? ST_GAP : ST_IDLE;
          end else begin
            state_d = ST_TONE;
            beep_d  = beep_q + 2'd1;
          end
        end
        if (key_req) begin
          key_pend_d = 1'b1;
        end
        // Requests from the error sequence itself are ignored; only a key sequence reacts.
        if (err_req && !err_seq_q) begin
`ifdef TONE_SEQ_PREEMPT_EN
          start_err = 1'b1;
`else
          err_pend_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_err) begin
      state_d    = ST_TONE;
      err_seq_d  = 1'b1;
      beep_d     = 2'd0;
      presc_d    = '0;
      tick_d     = '0;
      period_d   = ERR_PERIOD;
      duty_d     = ERR_DUTY;
      err_ack_d  = 1'b1;
      err_pend_d = 1'b0;
    end else if (start_key) begin
      state_d    = ST_TONE;
      err_seq_d  = 1'b0;
      beep_d     = 2'd0;
      presc_d    = '0;
      tick_d     = '0;
      period_d   = KEY_PERIOD;
      duty_d     = KEY_DUTY;
      key_ack_d  = 1'b1;
      key_pend_d = 1'b0;
    end

    pwm_rst_n_d = (state_d == ST_TONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      tick_q      <= '0;
      beep_q      <= '0;
      err_seq_q   <= 1'b0;
      key_pend_q  <= 1'b0;
      err_pend_q  <= 1'b0;
      period_q    <= '0;
      duty_q      <= '0;
      key_ack_q   <= 1'b0;
      err_ack_q   <= 1'b0;
      pwm_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      beep_q      <= beep_d;
      err_seq_q   <= err_seq_d;
      key_pend_q  <= key_pend_d;
      err_pend_q  <= err_pend_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      key_ack_q   <= key_ack_d;
      err_ack_q   <= err_ack_d;
      pwm_rst_n_q <= pwm_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign key_ack   = key_ack_q;
  assign err_ack   = err_ack_q;
  assign period    = period_q;
  assign duty      = duty_q;
  assign pwm_rst_n = pwm_rst_n_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with small tick parameters; handles both TONE_SEQ_PREEMPT_EN builds.
module tb_tone_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_req = 1'b0;
  logic        err_req = 1'b0;
  logic        key_ack;
  logic        err_ack;
  logic [31:0] period;
  logic [31:0] duty;
  logic        pwm_rst_n;
  logic        busy;

  int checks = 0;
  int failures = 0;

  tone_seq_ctrl #(
    .TICK_DIV  (4),
    .KEY_PERIOD(32'd7),
    .KEY_TICKS (2),
    .ERR_PERIOD(32'd9),
    .ERR_TICKS (3),
    .GAP_TICKS (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_req  (key_req),
    .err_req  (err_req),
    .key_ack  (key_ack),
    .err_ack  (err_ack),
    .period   (period),
    .duty     (duty),
    .pwm_rst_n(pwm_rst_n),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks forward while busy, starting with the current cycle; stops on the first idle cycle.
  // pat_err counts cycles whose pwm_rst_n differs from the three-beep error pattern.
  task automatic run_busy(output int busy_cyc, output int pwm_cyc, output int k_acks,
                          output int e_acks, output int pat_err);
    logic exp_pwm;
    busy_cyc = 0; pwm_cyc = 0; k_acks = 0; e_acks = 0; pat_err = 0;
    while (busy && busy_cyc < 200) begin
      exp_pwm = (busy_cyc < 12) || (busy_cyc >= 16 && busy_cyc < 28) || (busy_cyc >= 32);
      if (pwm_rst_n !== exp_pwm) pat_err++;
      if (pwm_rst_n) pwm_cyc++;
      if (key_ack) k_acks++;
      if (err_ack) e_acks++;
      busy_cyc++;
      step();
    end
  endtask

  int bc, pc, ka, ea, pe;

  initial begin
    // Reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_pwm", pwm_rst_n, 0);
    check("rst_period", period, 0);
    check("rst_duty", duty, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("idle_busy", busy, 0);

    // Single key click: ack next cycle, 8-cycle tone, then idle
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    check("key_ack", key_ack, 1);
    check("key_period", period, 7);
    check("key_duty", duty, 4);
    run_busy(bc, pc, ka, ea, pe);
    check("key_busy_cycles", bc, 8);
    check("key_pwm_cycles", pc, 8);
    check("key_acks", ka, 1);
    check("key_done_busy", busy, 0);
    check("key_done_pwm", pwm_rst_n, 0);
    check("key_hold_period", period, 7);
    step(); step();

    // Lone error alarm: three 12-cycle beeps separated by 4-cycle gaps
    err_req = 1'b1;
    step();
    err_req = 1'b0;
    check("err_ack", err_ack, 1);
    check("err_period", period, 9);
    check("err_duty", duty, 5);
    run_busy(bc, pc, ka, ea, pe);
    check("err_busy_cycles", bc, 44);
    check("err_pwm_cycles", pc, 36);
    check("err_acks", ea, 1);
    check("err_pattern_errs", pe, 0);
    step(); step();

    // Simultaneous requests: error first, one idle cycle, then the click
    key_req = 1'b1; err_req = 1'b1;
    step();
    key_req = 1'b0; err_req = 1'b0;
    check("both_err_ack", err_ack, 1);
    check("both_key_ack0", key_ack, 0);
    run_busy(bc, pc, ka, ea, pe);
    check("both_err_busy", bc, 44);
    check("both_no_key_ack", ka, 0);
    check("both_gap_idle", busy, 0);
    step();
    check("both_key_ack", key_ack, 1);
    check("both_key_period", period, 7);
    run_busy(bc, pc, ka, ea, pe);
    check("both_key_pwm", pc, 8);
    step(); step();

    // Error request during a key tone
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    step(); step();
    err_req = 1'b1;
    step();
    err_req = 1'b0;
`ifdef TONE_SEQ_PREEMPT_EN
    check("pre_err_ack", err_ack, 1);
    check("pre_period", period, 9);
    check("pre_pwm", pwm_rst_n, 1);
    run_busy(bc, pc, ka, ea, pe);
    check("pre_busy", bc, 44);
    check("pre_no_key", ka, 0);
    step();
    check("pre_no_retone", busy, 0);
`else
    check("pend_err_ack0", err_ack, 0);
    check("pend_period", period, 7);
    check("pend_pwm", pwm_rst_n, 1);
    run_busy(bc, pc, ka, ea, pe);
    check("pend_key_rest", bc, 5);
    check("pend_idle", busy, 0);
    step();
    check("pend_err_ack", err_ack, 1);
    check("pend_err_period", period, 9);
    run_busy(bc, pc, ka, ea, pe);
    check("pend_err_busy", bc, 44);
`endif
    step(); step();

    // Reset in the middle of the first error gap
    err_req = 1'b1;
    step();
    err_req = 1'b0;
    for (int i = 0; i < 13; i++) step();
    check("gap_pwm", pwm_rst_n, 0);
    check("gap_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_period", period, 0);
    check("arst_duty", duty, 0);
    check("arst_acks", {err_ack, key_ack, pwm_rst_n}, 0);
    #1 rst = 1'b0;
    pc = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy) bc++;
      if (pwm_rst_n) pc++;
    end
    check("post_rst_quiet", bc + pc, 0);
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    check("post_key_ack", key_ack, 1);
    check("post_key_period", period, 7);
    run_busy(bc, pc, ka, ea, pe);
    check("post_key_pwm", pc, 8);
    check("post_no_err", ea, 0);
    for (int i = 0; i < 20; i++) step();
    check("post_final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
